// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared definitions for the dmem_ctrl slice: port count,
//               RV32I load/store funct3 codes, controller state encoding and
//               helpers for request checking, load extension and store merge.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam int NUM_PORTS = 2;

    localparam logic [2:0] F3_B  = 3'b000;  // lb  / sb
    localparam logic [2:0] F3_H  = 3'b001;  // lh  / sh
    localparam logic [2:0] F3_W  = 3'b010;  // lw  / sw
    localparam logic [2:0] F3_BU = 3'b100;  // lbu
    localparam logic [2:0] F3_HU = 3'b101;  // lhu

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        MERGE  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Illegal funct3, misalignment or word index beyond the memory.
    function automatic logic req_error(input logic        we,
                                       input logic [2:0]  f3,
                                       input logic [31:0] addr,
                                       input int unsigned depth);
        logic bad_f3;
        logic misaligned;
        case (f3)
            F3_B, F3_H, F3_W: bad_f3 = 1'b0;
            F3_BU, F3_HU:     bad_f3 = we;   // no unsigned stores
            default:          bad_f3 = 1'b1;
        endcase
        if (f3 == F3_H || f3 == F3_HU)
            misaligned = addr[0];
        else if (f3 == F3_W)
            misaligned = |addr[1:0];
        else
            misaligned = 1'b0;
        return bad_f3 | misaligned | ({2'b00, addr[31:2]} >= depth);
    endfunction

    // Select the addressed lane of a read word and extend it.
    function automatic logic [31:0] load_ext(input logic [31:0] word,
                                             input logic [2:0]  f3,
                                             input logic [1:0]  off);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (f3)
            F3_B:    return {{24{sh[7]}}, sh[7:0]};
            F3_H:    return {{16{sh[15]}}, sh[15:0]};
            F3_BU:   return {24'd0, sh[7:0]};
            F3_HU:   return {16'd0, sh[15:0]};
            default: return word;
        endcase
    endfunction

    // Replace only the addressed byte/halfword lanes of the old word.
    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [15:0] data,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  off);
        logic [31:0] r;
        r = word;
        if (f3 == F3_B)
            r[{off, 3'b000} +: 8] = data[7:0];
        else
            r[{off[1], 4'b0000} +: 16] = data;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_ctrl_if
// Description : Requester and memory bus bundle of dmem_ctrl.
//               Requester side : req_valid/we/funct3/addr/wdata (per port),
//                                gnt, rsp_valid (per port), rsp_rdata, rsp_err
//               Memory side    : mem_en, mem_we, mem_addr, mem_wdata,
//                                mem_rdata (one-cycle read latency)
//               slave  modport : used by the controller
//               master modport : used by requesters / memory model
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_ctrl_if #(
    parameter int DEPTH = 32
);
    import dmem_pkg::*;

    logic [NUM_PORTS-1:0]        req_valid;
    logic [NUM_PORTS-1:0]        req_we;
    logic [NUM_PORTS-1:0][2:0]   req_funct3;
    logic [NUM_PORTS-1:0][31:0]  req_addr;
    logic [NUM_PORTS-1:0][31:0]  req_wdata;
    logic [NUM_PORTS-1:0]        gnt;
    logic [NUM_PORTS-1:0]        rsp_valid;
    logic [31:0]                 rsp_rdata;
    logic                        rsp_err;
    logic                        mem_en;
    logic                        mem_we;
    logic [$clog2(DEPTH)-1:0]    mem_addr;
    logic [31:0]                 mem_wdata;
    logic [31:0]                 mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output gnt, rsp_valid, rsp_rdata, rsp_err,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  gnt, rsp_valid, rsp_rdata, rsp_err,
               mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/dmem_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : dmem_rr_arb
// Description : Two-port arbiter producing a one-hot combinational grant.
//               clk, rst : clock / asynchronous active-high reset
//               req      : request vector
//               advance  : commit the current grant (updates priority)
//               gnt      : one-hot grant, zero when no request
//               Macro DMEM_CTRL_RR_EN selects round-robin; otherwise port 0
//               has fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_rr_arb
    import dmem_pkg::*;
(
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic [NUM_PORTS-1:0] req,
    input  wire logic                 advance,
    output logic      [NUM_PORTS-1:0] gnt
);

`ifdef DMEM_CTRL_RR_EN
    // Index of the most recently granted port; it gets lowest priority.
    // Reset value 1 makes port 0 the first choice.
    logic last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_q <= 1'b1;
        else if (advance && (|req))
            last_q <= gnt[1];
    end

    always_comb begin
        gnt = '0;
        if (last_q) begin
            if (req[0])      gnt = 2'b01;
            else if (req[1]) gnt = 2'b10;
        end else begin
            if (req[1])      gnt = 2'b10;
            else if (req[0]) gnt = 2'b01;
        end
    end
`else
    logic w_unused;
    assign w_unused = &{1'b0, clk, rst, advance};

    always_comb begin
        gnt = '0;
        if (req[0])      gnt = 2'b01;
        else if (req[1]) gnt = 2'b10;
    end
`endif

endmodule
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_ctrl
// Description : Two-requester data-memory controller for RV32I loads/stores.
//               One request in flight; sub-word stores are done as a
//               read-modify-write. All bus outputs are registered.
//               clk  : rising-edge clock
//               rst  : asynchronous active-high reset
//               bus  : dmem_ctrl_if.slave (requester + memory signals)
//               Macro DMEM_CTRL_RR_EN enables round-robin arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  wire logic  clk,
    input  wire logic  rst,
    dmem_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    state_t state_q, state_d;

    // Arbitration and winner's request
    logic [NUM_PORTS-1:0] w_arb_gnt;
    logic                 w_arb_adv;
    logic                 w_sel;
    logic                 w_we;
    logic [2:0]           w_f3;
    logic [31:0]          w_addr;
    logic [31:0]          w_wdata;
    logic                 w_err;
    logic                 w_latch;

    // Latched request (only the fields needed after IDLE)
    logic [NUM_PORTS-1:0] port_q;
    logic                 we_q;
    logic [2:0]           f3_q;
    logic [1:0]           off_q;
    logic [15:0]          wlo_q;
    logic                 err_q;

    // Registered outputs
    logic [NUM_PORTS-1:0] gnt_q, gnt_d;
    logic [NUM_PORTS-1:0] rsp_valid_q, rsp_valid_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [31:0]          rsp_rdata_q, rsp_rdata_d;
    logic                 mem_en_q, mem_en_d;
    logic                 mem_we_q, mem_we_d;
    logic [AW-1:0]        mem_addr_q, mem_addr_d;
    logic [31:0]          mem_wdata_q, mem_wdata_d;

    dmem_rr_arb u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.req_valid),
        .advance (w_arb_adv),
        .gnt     (w_arb_gnt)
    );

    assign w_sel   = w_arb_gnt[1];
    assign w_we    = bus.req_we[w_sel];
    assign w_f3    = bus.req_funct3[w_sel];
    assign w_addr  = bus.req_addr[w_sel];
    assign w_wdata = bus.req_wdata[w_sel];
    assign w_err   = req_error(w_we, w_f3, w_addr, DEPTH);

    // Memory outputs are computed from the next state so that the strobe is
    // visible during ACCESS (read/sw) and during DONE after MERGE (sb/sh).
    always_comb begin
        state_d     = state_q;
        gnt_d       = '0;
        rsp_valid_d = '0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        w_arb_adv   = 1'b0;
        w_latch     = 1'b0;

        case (state_q)
            IDLE: begin
                if (|bus.req_valid) begin
                    gnt_d     = w_arb_gnt;
                    w_arb_adv = 1'b1;
                    w_latch   = 1'b1;
                    if (w_err) begin
                        state_d = DONE;
                    end else begin
                        state_d    = ACCESS;
                        mem_en_d   = 1'b1;
                        mem_we_d   = w_we && (w_f3 == F3_W);
                        mem_addr_d = w_addr[AW+1:2];
                        if (w_we && (w_f3 == F3_W))
                            mem_wdata_d = w_wdata;
                    end
                end
            end
            ACCESS: begin
                state_d = (we_q && (f3_q != F3_W)) ? MERGE : DONE;
            end
            MERGE: begin
                mem_en_d    = 1'b1;
                mem_we_d    = 1'b1;
                mem_wdata_d = store_merge(bus.mem_rdata, wlo_q, f3_q, off_q);
                state_d     = DONE;
            end
            DONE: begin
                rsp_valid_d = port_q;
                rsp_err_d   = err_q;
                if (!err_q && !we_q)
                    rsp_rdata_d = load_ext(bus.mem_rdata, f3_q, off_q);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            port_q <= '0;
            we_q   <= 1'b0;
            f3_q   <= '0;
            off_q  <= '0;
            wlo_q  <= '0;
            err_q  <= 1'b0;
        end else if (w_latch) begin
            port_q <= w_arb_gnt;
            we_q   <= w_we;
            f3_q   <= w_f3;
            off_q  <= w_addr[1:0];
            wlo_q  <= w_wdata[15:0];
            err_q  <= w_err;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_ctrl
// Description : Directed self-checking bench for dmem_ctrl with a one-cycle
//               latency memory model. Honours DMEM_CTRL_RR_EN for the
//               arbitration expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_ctrl;
    import dmem_pkg::*;

    localparam int DEPTH = 32;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   men_cnt;
    int   rsp_cnt;
    logic [31:0] mem [DEPTH];

    dmem_ctrl_if #(.DEPTH(DEPTH)) bus ();

    dmem_ctrl #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: one-cycle read latency, write on strobe.
    always @(posedge clk) begin
        if (bus.mem_en) begin
            men_cnt++;
            if (bus.mem_we)
                mem[bus.mem_addr] <= bus.mem_wdata;
            else
                bus.mem_rdata <= mem[bus.mem_addr];
        end
        if (|bus.rsp_valid)
            rsp_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input int p, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int exp_lat, input logic exp_err,
                          input logic [31:0] exp_rd, input string tag);
        bit got;
        int lat;
        int men0;
        @(negedge clk);
        bus.req_valid[p]  = 1'b1;
        bus.req_we[p]     = we;
        bus.req_funct3[p] = f3;
        bus.req_addr[p]   = addr;
        bus.req_wdata[p]  = wd;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            if (bus.gnt != '0) got = 1'b1;
        end
        check({tag, "_gnt"}, 32'(bus.gnt), 32'(2'b01 << p));
        bus.req_valid[p] = 1'b0;
        men0 = men_cnt;
        got  = 1'b0;
        lat  = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            lat++;
            if (bus.rsp_valid != '0) got = 1'b1;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_rspv"}, 32'(bus.rsp_valid), 32'(2'b01 << p));
        check({tag, "_err"}, 32'(bus.rsp_err), 32'(exp_err));
        check({tag, "_rdata"}, bus.rsp_rdata, exp_rd);
        if (exp_err)
            check({tag, "_nomem"}, men_cnt - men0, 0);
        @(posedge clk); #1;
        check({tag, "_pulse"}, 32'(bus.rsp_valid), 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_gnt"},   32'(bus.gnt), 0);
        check({tag, "_rspv"},  32'(bus.rsp_valid), 0);
        check({tag, "_rerr"},  32'(bus.rsp_err), 0);
        check({tag, "_rdata"}, bus.rsp_rdata, 0);
        check({tag, "_men"},   32'(bus.mem_en), 0);
        check({tag, "_mwe"},   32'(bus.mem_we), 0);
        check({tag, "_maddr"}, 32'(bus.mem_addr), 0);
        check({tag, "_mwd"},   bus.mem_wdata, 0);
    endtask

    initial begin
        logic [1:0] g [4];
        logic [1:0] exp_g [4];
        int   ng;
        int   rsp0;
        bit   got;

        checks         = 0;
        failures       = 0;
        men_cnt        = 0;
        rsp_cnt        = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
        bus.req_valid  = '0;
        bus.req_we     = '0;
        bus.req_funct3 = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.mem_rdata  = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Word store / load round trip
        do_req(0, 1'b1, F3_W, 32'h08, 32'h12345678, 2, 1'b0, 32'h0, "sw08");
        check("mem2_sw", mem[2], 32'h12345678);
        do_req(0, 1'b0, F3_W, 32'h08, 32'h0, 2, 1'b0, 32'h12345678, "lw08");

        // Byte store merge and signed/unsigned byte loads
        do_req(0, 1'b1, F3_B, 32'h09, 32'h000000AB, 3, 1'b0, 32'h0, "sb09");
        do_req(0, 1'b0, F3_W, 32'h08, 32'h0, 2, 1'b0, 32'h1234AB78, "lw08b");
        do_req(0, 1'b0, F3_B, 32'h09, 32'h0, 2, 1'b0, 32'hFFFFFFAB, "lb09");
        do_req(0, 1'b0, F3_BU, 32'h09, 32'h0, 2, 1'b0, 32'h000000AB, "lbu09");

        // Halfword store from port 1 into the upper lanes
        do_req(1, 1'b1, F3_H, 32'h0A, 32'h00008001, 3, 1'b0, 32'h0, "sh0A");
        check("mem2_sh", mem[2], 32'h8001AB78);
        do_req(1, 1'b0, F3_H, 32'h0A, 32'h0, 2, 1'b0, 32'hFFFF8001, "lh0A");
        do_req(1, 1'b0, F3_HU, 32'h0A, 32'h0, 2, 1'b0, 32'h00008001, "lhu0A");
        do_req(0, 1'b0, F3_B, 32'h0B, 32'h0, 2, 1'b0, 32'hFFFFFF80, "lb0B");

        // Error cases
        do_req(0, 1'b0, F3_H, 32'h0B, 32'h0, 1, 1'b1, 32'h0, "lh0B");
        do_req(0, 1'b0, F3_W, 32'h0A, 32'h0, 1, 1'b1, 32'h0, "lw0A");
        do_req(0, 1'b0, F3_W, 32'h80, 32'h0, 1, 1'b1, 32'h0, "lw80");
        do_req(1, 1'b1, F3_W, 32'h0E, 32'hDEADBEEF, 1, 1'b1, 32'h0, "sw0E");
        do_req(0, 1'b0, 3'b011, 32'h08, 32'h0, 1, 1'b1, 32'h0, "f3_011");
        do_req(1, 1'b1, F3_BU, 32'h08, 32'h0, 1, 1'b1, 32'h0, "st_f3bu");
        check("mem2_kept", mem[2], 32'h8001AB78);
        do_req(0, 1'b0, F3_W, 32'h7C, 32'h0, 2, 1'b0, 32'h0, "lw7C");

        // Reset during MERGE of a byte store
        do_req(0, 1'b1, F3_W, 32'h10, 32'hCAFEF00D, 2, 1'b0, 32'h0, "sw10");
        rsp0 = rsp_cnt;
        @(negedge clk);
        bus.req_valid[0]  = 1'b1;
        bus.req_we[0]     = 1'b1;
        bus.req_funct3[0] = F3_B;
        bus.req_addr[0]   = 32'h10;
        bus.req_wdata[0]  = 32'h55;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            if (bus.gnt != '0) got = 1'b1;
        end
        check("rm_gnt", 32'(bus.gnt), 32'h1);
        bus.req_valid[0] = 1'b0;
        @(posedge clk); #1;       // now in MERGE
        rst = 1'b1;
        #1;
        check_idle_outputs("rm_async");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rm_mem4", mem[4], 32'hCAFEF00D);
        check("rm_norsp", rsp_cnt - rsp0, 0);
        do_req(0, 1'b0, F3_W, 32'h10, 32'h0, 2, 1'b0, 32'hCAFEF00D, "rm_lw10");

        // Arbitration: reset must restore port-0 priority after a port-0 grant
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            bus.req_valid[p]  = 1'b1;
            bus.req_we[p]     = 1'b0;
            bus.req_funct3[p] = F3_W;
            bus.req_addr[p]   = 32'h08;
            bus.req_wdata[p]  = 32'h0;
        end
        ng = 0;
        for (int i = 0; i < 40 && ng < 4; i++) begin
            @(posedge clk); #1;
            if (bus.gnt != '0) begin
                g[ng] = bus.gnt;
                ng++;
            end
        end
        bus.req_valid = '0;
`ifdef DMEM_CTRL_RR_EN
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
`else
        exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01; exp_g[3] = 2'b01;
`endif
        check("arb_count", ng, 4);
        for (int k = 0; k < 4; k++)
            check($sformatf("arb_gnt%0d", k), (k < ng) ? 32'(g[k]) : 32'h0, 32'(exp_g[k]));
        repeat (6) @(posedge clk);
        #1;
        check("final_rspv", 32'(bus.rsp_valid), 0);
        check("final_men", 32'(bus.mem_en), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 32, the number of 32-bit words in the backing memory.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port req_valid, input, 2, per-requester request valid (bit0 = CPU, bit1 = loader/DMA).
REQ-005 SHALL have port req_we, input, 2, per-requester store (1) / load (0).
REQ-006 SHALL have port req_funct3, input, 2x3, per-requester RV32I funct3 size/sign code.
REQ-007 SHALL have port req_addr, input, 2x32, per-requester byte address.
REQ-008 SHALL have port req_wdata, input, 2x32, per-requester store data, right-aligned.
REQ-009 SHALL have port gnt, output, 2, one-cycle one-hot accept pulse.
REQ-010 SHALL have port rsp_valid, output, 2, one-cycle one-hot completion pulse to the granted requester.
REQ-011 SHALL have port rsp_rdata, output, 32, extended load data; 0 for stores and errors.
REQ-012 SHALL have port rsp_err, output, 1, qualified by rsp_valid: misaligned, out-of-range or illegal funct3.
REQ-013 SHALL have port mem_en, output, 1, memory access strobe.
REQ-014 SHALL have port mem_we, output, 1, memory write strobe (only with mem_en).
REQ-015 SHALL have port mem_addr, output, $clog2(DEPTH), word index = addr[..:2].
REQ-016 SHALL have ports mem_wdata (output, 32) and mem_rdata (input, 32); memory read latency is one cycle.

Function
REQ-017 SHALL use FSM states IDLE, ACCESS, MERGE, DONE; only IDLE samples req_valid.
REQ-018 In IDLE with any req_valid, SHALL pulse gnt for the arbitration winner, latch its request, and go to ACCESS; an erroring request goes directly to DONE with no mem_en.
REQ-019 Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores: 000 sb, 001 sh, 010 sw; any other code SHALL error.
REQ-020 Misaligned (lh/lhu/sh addr[0]!=0; lw/sw addr[1:0]!=0) or addr[31:2] >= DEPTH SHALL error.
REQ-021 ACCESS: lw/lh/lb/lbu/lhu/sb/sh SHALL issue a read (mem_en=1, mem_we=0); sw SHALL issue a write of req_wdata; next state DONE, or MERGE for sb/sh.
REQ-022 MERGE SHALL write mem_rdata with only the addressed byte/halfword lanes replaced by req_wdata[7:0]/[15:0]; other lanes are preserved.
REQ-023 DONE SHALL pulse rsp_valid for the granted port and return to IDLE; loads SHALL select the lane by addr[1:0] and sign-extend (lb, lh) or zero-extend (lbu, lhu).
REQ-024 Latency from gnt to rsp_valid SHALL be 2 cycles for loads and sw, 3 for sb/sh, and 1 for errors; throughput is one request in flight.
REQ-025 gnt, rsp_valid, rsp_err, rsp_rdata, mem_en, mem_we, mem_addr and mem_wdata SHALL be registered outputs.
REQ-026 A requester SHALL hold req_* stable until gnt; dropping req_valid before gnt SHALL leave no effect.

Reset
REQ-027 rst SHALL force IDLE, all outputs to 0, and arbitration priority to port 0, asynchronously.
REQ-028 Reset mid-operation SHALL abort without completing any pending write and without a response pulse.

Configuration
REQ-029 With DMEM_CTRL_RR_EN defined, arbitration SHALL be round-robin: the last granted port has lowest priority next time.
REQ-030 Without DMEM_CTRL_RR_EN, arbitration SHALL be fixed priority with port 0 always winning.

Structure
REQ-031 Package dmem_pkg SHALL hold the funct3 constants, the FSM state enum, and the NUM_PORTS=2 constant.
REQ-032 Arbitration SHALL be sub-module dmem_rr_arb (req[1:0], advance -> gnt one-hot), with the round-robin pointer gated by DMEM_CTRL_RR_EN.

Verification
REQ-033 Port0 sw addr 0x08 data 0x12345678, then lw 0x08: SHALL return 0x12345678, rsp_err=0, 2-cycle latency each.
REQ-034 sb addr 0x09 data 0xAB over word 0x12345678, then lw 0x08: SHALL return 0x1234AB78; lb 0x09 SHALL return 0xFFFFFFAB; lbu 0x09 SHALL return 0x000000AB.
REQ-035 lh addr 0x0B or lw addr 0x0A SHALL give rsp_err=1 at 1-cycle latency with mem_en never asserted; addr 0x80 with DEPTH=32 SHALL also error.
REQ-036 Both ports requesting continuously: with RR_EN, SHALL grant alternately 0,1,0,1; without RR_EN, SHALL grant port 0 only.
REQ-037 rst asserted during MERGE of sb: SHALL leave mem_we=0 and target word unchanged, with no rsp_valid, and the next request SHALL be served normally.
